// File: rtl/wbu_hostmux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wbu_hostmux_pkg
// Description : Shared constants and types for the debug-bus / console
//               UART multiplexer. Bit 7 of every link byte is the channel
//               tag and the low seven bits carry the character.
// Revision    : 1.0  initial release
// ============================================================================
package wbu_hostmux_pkg;

    localparam int   CHAR_W  = 7;
    localparam logic TAG_DBG = 1'b1;
    localparam logic TAG_CON = 1'b0;

    typedef logic [CHAR_W-1:0] char_t;
    typedef logic [CHAR_W:0]   link_byte_t;

    // Builds a link byte from a channel tag and a 7-bit character.
    function automatic link_byte_t tag_char(input logic tag, input char_t c);
        return {tag, c};
    endfunction

endpackage
`default_nettype wire

// File: rtl/wbu_hostmux_if.sv
`default_nettype none
// ============================================================================
// Module      : wbu_hostmux_if
// Description : Bundle of every handshake/data signal of wbu_hostmux.
//               slave  : the multiplexer itself
//               master : the surrounding logic (host engine, console, UART)
//   dbg_stb/dbg_data/dbg_busy       debug byte to send (7 bit) + backpressure
//   con_stb/con_data/con_busy       console byte to send (7 bit) + FIFO full
//   tx_stb/tx_data/tx_busy          tagged byte to the UART transmitter
//   rx_stb/rx_data                  tagged byte from the UART receiver
//   dbg_rx_stb/dbg_rx_data          received debug byte
//   con_rx_stb/con_rx_data          received console byte
//   link_active                     far-end debug port alive
// Revision    : 1.0  initial release
// ============================================================================
interface wbu_hostmux_if;

    logic       dbg_stb;
    logic [6:0] dbg_data;
    logic       dbg_busy;
    logic       con_stb;
    logic [6:0] con_data;
    logic       con_busy;
    logic       tx_stb;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       rx_stb;
    logic [7:0] rx_data;
    logic       dbg_rx_stb;
    logic [6:0] dbg_rx_data;
    logic       con_rx_stb;
    logic [6:0] con_rx_data;
    logic       link_active;

    modport slave (
        input  dbg_stb, dbg_data, con_stb, con_data, tx_busy, rx_stb, rx_data,
        output dbg_busy, con_busy, tx_stb, tx_data,
               dbg_rx_stb, dbg_rx_data, con_rx_stb, con_rx_data, link_active
    );

    modport master (
        output dbg_stb, dbg_data, con_stb, con_data, tx_busy, rx_stb, rx_data,
        input  dbg_busy, con_busy, tx_stb, tx_data,
               dbg_rx_stb, dbg_rx_data, con_rx_stb, con_rx_data, link_active
    );

endinterface
`default_nettype wire

// File: rtl/wbu_hostmux.sv
`default_nettype none
// ============================================================================
// Module      : wbu_hostmux
// Description : Merges a 7-bit debug stream and a buffered 7-bit console
//               stream onto one tagged UART byte stream (bit 7: 1 = debug,
//               0 = console), splits the received stream back into the two
//               channels and tracks far-end debug-port liveness.
// Ports       : clk  - clock
//               rst  - synchronous active-high reset
//               bus  - wbu_hostmux_if.slave (all data/handshake signals)
// Parameters  : LGCON_FIFO - log2 console FIFO depth (>= 1)
//               MAX_BURST  - debug bytes in a row while console waits (>= 1)
//               LGTIMEOUT  - link timeout counter width, 0 = sticky flag
// Revision    : 1.0  initial release
// ============================================================================
module wbu_hostmux
    import wbu_hostmux_pkg::*;
#(
    parameter int LGCON_FIFO = 4,
    parameter int MAX_BURST  = 8,
    parameter int LGTIMEOUT  = 24
) (
    input  logic           clk,
    input  logic           rst,
    wbu_hostmux_if.slave   bus
);

    localparam int                  c_depth      = 1 << LGCON_FIFO;
    localparam logic [LGCON_FIFO:0] c_full_count = (LGCON_FIFO+1)'(c_depth);
    localparam int                  c_burst_w    = $clog2(MAX_BURST + 1);
    localparam logic [c_burst_w-1:0] c_max_burst = c_burst_w'(MAX_BURST);

    // ---------------- console FIFO ----------------
    char_t                  r_mem [c_depth];
    logic [LGCON_FIFO-1:0]  r_wr_ptr;
    logic [LGCON_FIFO-1:0]  r_rd_ptr;
    logic [LGCON_FIFO:0]    r_count;

    logic                   r_ps_full;
    link_byte_t             r_ps_data;
    logic [c_burst_w-1:0]   r_burst;

    logic w_con_empty, w_con_full, w_push, w_dbg_busy, w_dbg_take, w_con_take;

    assign w_con_empty = (r_count == '0);
    assign w_con_full  = (r_count == c_full_count);
    assign w_push      = bus.con_stb && !w_con_full;

    // Debug is stalled only by a full holding register or an exhausted burst
    // allowance with console data waiting; otherwise it always wins.
    assign w_dbg_busy  = r_ps_full || (!w_con_empty && (r_burst == c_max_burst));
    assign w_dbg_take  = bus.dbg_stb && !w_dbg_busy;
    assign w_con_take  = !r_ps_full && !w_dbg_take && !w_con_empty;

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= bus.con_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_con_take)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_con_take})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ---------------- holding register and burst counter ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ps_full <= 1'b0;
            r_ps_data <= '0;
            r_burst   <= '0;
        end else begin
            if (r_ps_full) begin
                if (!bus.tx_busy)
                    r_ps_full <= 1'b0;
            end else if (w_dbg_take) begin
                r_ps_full <= 1'b1;
                r_ps_data <= tag_char(TAG_DBG, bus.dbg_data);
            end else if (w_con_take) begin
                r_ps_full <= 1'b1;
                r_ps_data <= tag_char(TAG_CON, r_mem[r_rd_ptr]);
            end

            if (w_con_take || w_con_empty)
                r_burst <= '0;
            else if (w_dbg_take && (r_burst != c_max_burst))
                r_burst <= r_burst + 1'b1;
        end
    end

    // ---------------- RX split ----------------
    logic  r_dbg_rx_stb, r_con_rx_stb, r_link;
    char_t r_dbg_rx_data, r_con_rx_data;
    logic  w_rx_dbg;

    assign w_rx_dbg = bus.rx_stb && bus.rx_data[7];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dbg_rx_stb  <= 1'b0;
            r_con_rx_stb  <= 1'b0;
            r_dbg_rx_data <= '0;
            r_con_rx_data <= '0;
        end else begin
            r_dbg_rx_stb <= w_rx_dbg;
            r_con_rx_stb <= bus.rx_stb && !bus.rx_data[7];
            if (bus.rx_stb) begin
                r_dbg_rx_data <= bus.rx_data[6:0];
                r_con_rx_data <= bus.rx_data[6:0];
            end
        end
    end

    // ---------------- link activity ----------------
    generate
        if (LGTIMEOUT > 0) begin : g_timeout
            logic [LGTIMEOUT-1:0] r_timeout;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_timeout <= '0;
                    r_link    <= 1'b0;
                end else if (w_rx_dbg) begin
                    r_timeout <= '1;
                    r_link    <= 1'b1;
                end else if (r_timeout != '0) begin
                    r_timeout <= r_timeout - 1'b1;
                    // Drop the flag on the same edge the counter hits zero.
                    if (r_timeout == LGTIMEOUT'(1))
                        r_link <= 1'b0;
                end
            end
        end else begin : g_sticky
            always_ff @(posedge clk) begin
                if (rst)
                    r_link <= 1'b0;
                else if (w_rx_dbg)
                    r_link <= 1'b1;
            end
        end
    endgenerate

    // ---------------- outputs ----------------
    assign bus.tx_stb      = r_ps_full;
    assign bus.tx_data     = r_ps_data;
    assign bus.dbg_busy    = w_dbg_busy;
    assign bus.con_busy    = w_con_full;
    assign bus.dbg_rx_stb  = r_dbg_rx_stb;
    assign bus.dbg_rx_data = r_dbg_rx_data;
    assign bus.con_rx_stb  = r_con_rx_stb;
    assign bus.con_rx_data = r_con_rx_data;
    assign bus.link_active = r_link;

endmodule
`default_nettype wire

// File: tb/tb_wbu_hostmux.sv
`default_nettype none
// ============================================================================
// Module      : tb_wbu_hostmux
// Description : Directed self-checking bench for wbu_hostmux. Expected TX
//               bytes are queued when stimulus is planned and popped by a
//               monitor whenever the UART side accepts a byte.
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_wbu_hostmux;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wbu_hostmux_if bus_if ();

    wbu_hostmux #(
        .LGCON_FIFO (4),
        .MAX_BURST  (8),
        .LGTIMEOUT  (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q [$];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    // Scoreboard: a byte leaves on every edge where tx_stb && !tx_busy.
    always @(negedge clk) begin
        if (!rst && bus_if.tx_stb && !bus_if.tx_busy) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                assert (exp_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL tx_unexpected: observed 0x%02h expected nothing", bus_if.tx_data);
                end
            end else begin
                check("tx_byte", bus_if.tx_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $error("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entry and exit just after a rising edge; strobe stays high across
    // back-to-back calls so a stream looks continuous to the DUT.
    task automatic send_dbg(input logic [6:0] d);
        logic ok;
        ok = 1'b0;
        bus_if.dbg_stb  = 1'b1;
        bus_if.dbg_data = d;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!bus_if.dbg_busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("dbg_accept", {7'd0, ok}, 8'd1);
        step();
        bus_if.dbg_stb = 1'b0;
    endtask

    task automatic send_con(input logic [6:0] d);
        logic ok;
        ok = 1'b0;
        bus_if.con_stb  = 1'b1;
        bus_if.con_data = d;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!bus_if.con_busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("con_accept", {7'd0, ok}, 8'd1);
        step();
        bus_if.con_stb = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 400; i++) begin
            if (exp_q.size() == 0)
                break;
            @(negedge clk);
        end
        check(tag, 8'(exp_q.size()), 8'd0);
    endtask

    initial begin
        rst             = 1'b1;
        bus_if.dbg_stb  = 1'b0;
        bus_if.dbg_data = '0;
        bus_if.con_stb  = 1'b0;
        bus_if.con_data = '0;
        bus_if.tx_busy  = 1'b0;
        bus_if.rx_stb   = 1'b0;
        bus_if.rx_data  = '0;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx_stb",      {7'd0, bus_if.tx_stb},      8'd0);
        check("rst_tx_data",     bus_if.tx_data,             8'd0);
        check("rst_dbg_busy",    {7'd0, bus_if.dbg_busy},    8'd0);
        check("rst_con_busy",    {7'd0, bus_if.con_busy},    8'd0);
        check("rst_dbg_rx_stb",  {7'd0, bus_if.dbg_rx_stb},  8'd0);
        check("rst_dbg_rx_data", {1'b0, bus_if.dbg_rx_data}, 8'd0);
        check("rst_con_rx_stb",  {7'd0, bus_if.con_rx_stb},  8'd0);
        check("rst_con_rx_data", {1'b0, bus_if.con_rx_data}, 8'd0);
        check("rst_link_active", {7'd0, bus_if.link_active}, 8'd0);
        step();
        rst = 1'b0;

        // ---- idle: nothing transmitted ----
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("idle_tx_stb", {7'd0, bus_if.tx_stb}, 8'd0);
        end

        // ---- held debug strobe: one byte every two cycles ----
        step();
        bus_if.dbg_stb  = 1'b1;
        bus_if.dbg_data = 7'h41;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("dbg_busy_alt", {7'd0, bus_if.dbg_busy}, 8'(i % 2));
            if (i % 2 == 0)
                exp_q.push_back(8'hC1);
        end
        step();
        bus_if.dbg_stb = 1'b0;
        drain("drain_dbg_stream");

        // ---- burst limit: 8 debug, 1 console, repeat ----
        step();
        exp_q.push_back(8'hC0);
        for (int g = 0; g < 3; g++) begin
            for (int k = 0; k < 8; k++)
                exp_q.push_back(8'h80 | 8'(g * 8 + k));
            exp_q.push_back(8'(g + 1));
        end
        exp_q.push_back(8'h80 | 8'd24);
        exp_q.push_back(8'h80 | 8'd25);
        bus_if.tx_busy = 1'b1;
        send_dbg(7'h40);
        send_con(7'h01);
        send_con(7'h02);
        send_con(7'h03);
        bus_if.tx_busy = 1'b0;
        for (int k = 0; k < 26; k++)
            send_dbg(7'(k));
        drain("drain_burst");

        // ---- console FIFO fill to full, overflow refused ----
        step();
        bus_if.tx_busy = 1'b1;
        exp_q.push_back(8'hFF);
        send_dbg(7'h7F);
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'h10 + 8'(i));
            send_con(7'h10 + 7'(i));
        end
        @(negedge clk);
        check("fifo_full_busy", {7'd0, bus_if.con_busy}, 8'd1);
        step();
        bus_if.con_stb  = 1'b1;
        bus_if.con_data = 7'h55;
        @(negedge clk);
        check("fifo_overflow_busy", {7'd0, bus_if.con_busy}, 8'd1);
        step();
        bus_if.con_stb = 1'b0;
        bus_if.tx_busy = 1'b0;
        drain("drain_fifo");
        repeat (5) @(negedge clk);
        check("fifo_empty_busy", {7'd0, bus_if.con_busy}, 8'd0);

        // ---- RX split and link activity (counter width 4) ----
        step();
        bus_if.rx_stb  = 1'b1;
        bus_if.rx_data = 8'h85;
        step();
        bus_if.rx_data = 8'h33;
        @(negedge clk);
        check("rx_dbg_stb",    {7'd0, bus_if.dbg_rx_stb},  8'd1);
        check("rx_dbg_data",   {1'b0, bus_if.dbg_rx_data}, 8'h05);
        check("rx_con_stb_0",  {7'd0, bus_if.con_rx_stb},  8'd0);
        check("rx_link_set",   {7'd0, bus_if.link_active}, 8'd1);
        step();
        bus_if.rx_stb = 1'b0;
        @(negedge clk);
        check("rx_con_stb",    {7'd0, bus_if.con_rx_stb},  8'd1);
        check("rx_con_data",   {1'b0, bus_if.con_rx_data}, 8'h33);
        check("rx_dbg_stb_0",  {7'd0, bus_if.dbg_rx_stb},  8'd0);
        check("rx_link_hold",  {7'd0, bus_if.link_active}, 8'd1);
        // The debug byte was captured on edge P0; flag holds through P14.
        repeat (13) @(posedge clk);
        @(negedge clk);
        check("link_before_timeout", {7'd0, bus_if.link_active}, 8'd1);
        @(negedge clk);
        check("link_after_timeout",  {7'd0, bus_if.link_active}, 8'd0);

        // ---- reset while a byte is held ----
        step();
        bus_if.tx_busy = 1'b1;
        send_dbg(7'h11);
        send_con(7'h22);
        send_con(7'h23);
        @(negedge clk);
        check("held_tx_stb", {7'd0, bus_if.tx_stb}, 8'd1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_tx_stb",   {7'd0, bus_if.tx_stb},   8'd0);
        check("post_rst_con_busy", {7'd0, bus_if.con_busy}, 8'd0);
        check("post_rst_dbg_busy", {7'd0, bus_if.dbg_busy}, 8'd0);
        step();
        bus_if.tx_busy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("post_rst_discard", {7'd0, bus_if.tx_stb}, 8'd0);
        end

        check("scoreboard_empty", 8'(exp_q.size()), 8'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
